// File: rtl/db_req_arbiter.sv
// rtl/db_req_arbiter.sv - two-port request arbiter in front of a shared KV DB
module db_req_arbiter #(
    parameter int KEY_SIZE   = 96,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                clk156,
    input  logic                eth_rst_n,
    input  logic [KEY_SIZE-1:0] req0_key,
    input  logic [3:0]          req0_flag,
    input  logic                req0_valid,
    input  logic [KEY_SIZE-1:0] req1_key,
    input  logic [3:0]          req1_flag,
    input  logic                req1_valid,
    output logic                rsp0_valid,
    output logic [3:0]          rsp0_flag,
    output logic                rsp1_valid,
    output logic [3:0]          rsp1_flag,
    output logic [KEY_SIZE-1:0] db_key,
    output logic [3:0]          db_flag,
    output logic                db_valid,
    input  logic                db_ready,
    input  logic                db_rsp_valid,
    input  logic [3:0]          db_rsp_flag,
    output logic [7:0]          drop_cnt0,
    output logic [7:0]          drop_cnt1,
    output logic [7:0]          timeout_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = KEY_SIZE + 4;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // Per-port request queues, index 0/1 is the parser port
    logic [EW-1:0] mem_q    [2][FIFO_DEPTH];
    logic [PW:0]   wr_ptr_q [2];
    logic [PW:0]   rd_ptr_q [2];
    logic [7:0]    drop_cnt_q [2];

    logic [1:0]    req_v;
    logic [EW-1:0] req_e [2];
    logic [EW-1:0] head  [2];
    logic [1:0]    empty;
    logic [1:0]    full;
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    drop;
    logic          grant_any;
    logic          grant_sel;

    // Arbiter / DB-side state
    state_t        state_q;
    logic          grant_port_q;
    logic          last_grant_q;
    logic [TW-1:0] timer_q;
    logic          db_valid_q;
    logic [KEY_SIZE-1:0] db_key_q;
    logic [3:0]    db_flag_q;
    logic          rsp0_valid_q;
    logic          rsp1_valid_q;
    logic [3:0]    rsp0_flag_q;
    logic [3:0]    rsp1_flag_q;
    logic [7:0]    timeout_cnt_q;
    logic          reply_now;
    logic [3:0]    reply_flag;

    // Queue status, round-robin grant and push/pop/drop decisions
    always_comb begin
        req_v    = {req1_valid, req0_valid};
        req_e[0] = {req0_key, req0_flag};
        req_e[1] = {req1_key, req1_flag};
        for (int p = 0; p < 2; p++) begin
            empty[p] = (wr_ptr_q[p] == rd_ptr_q[p]);
            full[p]  = (wr_ptr_q[p][PW] != rd_ptr_q[p][PW]) &&
                       (wr_ptr_q[p][PW-1:0] == rd_ptr_q[p][PW-1:0]);
            head[p]  = mem_q[p][rd_ptr_q[p][PW-1:0]];
        end
        grant_any = (state_q == S_IDLE) && (empty != 2'b11);
        // On a tie the port that did not win last time goes first
        if (!empty[0] && !empty[1]) begin
            grant_sel = ~last_grant_q;
        end else begin
            grant_sel = empty[0];
        end
        for (int p = 0; p < 2; p++) begin
            pop[p]  = grant_any && (grant_sel == 1'(p));
            // A pop in the same cycle frees a slot, so a full queue still accepts
            push[p] = req_v[p] && (!full[p] || pop[p]);
            drop[p] = req_v[p] && full[p] && !pop[p];
        end
        // A reply racing the timeout wins; the flag then comes from the DB
        reply_now  = (state_q == S_WAIT) && (db_rsp_valid || (timer_q == TIMER_LAST));
        reply_flag = db_rsp_valid ? db_rsp_flag : 4'b0000;
    end

    // Queue storage writes; contents are don't-care while a slot is empty
    always_ff @(posedge clk156) begin
        for (int p = 0; p < 2; p++) begin
            if (push[p]) begin
                mem_q[p][wr_ptr_q[p][PW-1:0]] <= req_e[p];
            end
        end
    end

    // Queue pointers and saturating drop counters
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p]   <= '0;
                rd_ptr_q[p]   <= '0;
                drop_cnt_q[p] <= 8'd0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (push[p]) begin
                    wr_ptr_q[p] <= wr_ptr_q[p] + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr_q[p] <= rd_ptr_q[p] + 1'b1;
                end
                if (drop[p] && (drop_cnt_q[p] != 8'hFF)) begin
                    drop_cnt_q[p] <= drop_cnt_q[p] + 8'd1;
                end
            end
        end
    end

    // Single-outstanding FSM: grant, hold request until accepted, await reply or timeout
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q       <= S_IDLE;
            grant_port_q  <= 1'b0;
            last_grant_q  <= 1'b1;
            timer_q       <= '0;
            db_valid_q    <= 1'b0;
            db_key_q      <= '0;
            db_flag_q     <= 4'd0;
            rsp0_valid_q  <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp0_flag_q   <= 4'd0;
            rsp1_flag_q   <= 4'd0;
            timeout_cnt_q <= 8'd0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        {db_key_q, db_flag_q} <= head[grant_sel];
                        grant_port_q          <= grant_sel;
                        db_valid_q            <= 1'b1;
                        state_q               <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (db_ready) begin
                        db_valid_q <= 1'b0;
                        timer_q    <= '0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (reply_now) begin
                        if (grant_port_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_flag_q  <= reply_flag;
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_flag_q  <= reply_flag;
                        end
                        if (!db_rsp_valid && (timeout_cnt_q != 8'hFF)) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                        last_grant_q <= grant_port_q;
                        state_q      <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign db_valid    = db_valid_q;
    assign db_key      = db_key_q;
    assign db_flag     = db_flag_q;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp0_flag   = rsp0_flag_q;
    assign rsp1_flag   = rsp1_flag_q;
    assign drop_cnt0   = drop_cnt_q[0];
    assign drop_cnt1   = drop_cnt_q[1];
    assign timeout_cnt = timeout_cnt_q;

endmodule

// File: doc/db_req_arbiter.md
DB_REQ_ARBITER -- requirements
Module: db_req_arbiter

Interface
REQ-001 Parameter KEY_SIZE, default 96, lookup key width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, per-port request queue depth; power of two, at least 2.
REQ-003 Parameter TIMEOUT, default 64, cycles to wait in WAIT for a DB reply; at least 2.
REQ-004 clk156  in  1  single clock for all logic.
REQ-005 eth_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 req0_key / req1_key  in  KEY_SIZE  lookup key from parser port 0 / 1.
REQ-007 req0_flag / req1_flag  in  4  DB op flag from port 0 / 1.
REQ-008 req0_valid / req1_valid  in  1  one-cycle request strobe; no ready signal is returned.
REQ-009 rsp0_valid / rsp1_valid  out  1  one-cycle reply strobe to port 0 / 1.
REQ-010 rsp0_flag / rsp1_flag  out  4  reply flag to port 0 / 1.
REQ-011 db_key  out  KEY_SIZE  key presented to the shared KV DB.
REQ-012 db_flag  out  4  op flag presented to the DB.
REQ-013 db_valid  out  1  DB request valid.
REQ-014 db_ready  in  1  DB accepts the request.
REQ-015 db_rsp_valid  in  1  DB reply strobe.
REQ-016 db_rsp_flag  in  4  DB reply flag.
REQ-017 drop_cnt0 / drop_cnt1  out  8  saturating count of requests dropped on a full queue.
REQ-018 timeout_cnt  out  8  saturating count of DB timeouts.

Function
REQ-019 Each port SHALL have a FIFO_DEPTH-entry queue of {key, flag}; reqN_valid with the queue not full writes the entry at that clock edge.
REQ-020 reqN_valid with the queue full SHALL drop the request, leave the queue unchanged and increment drop_cntN, saturating at 255.
REQ-021 A push and a pop on the same queue in the same cycle SHALL both take effect, including when the queue is full.
REQ-022 The FSM SHALL have three states: IDLE, ISSUE and WAIT; only one DB request is outstanding at any time.
REQ-023 IDLE: if any queue is non-empty, grant round-robin.
  - If both queues are non-empty, grant the port that is not last_grant.
  - If one queue is non-empty, grant that port.
  - Load the head entry into db_key/db_flag, pop it, latch grant_port, go to ISSUE.
REQ-024 ISSUE: db_valid = 1; db_key and db_flag SHALL stay stable until db_ready; on db_valid and db_ready go to WAIT and clear the timer.
REQ-025 WAIT: db_valid = 0.
  - On db_rsp_valid: next cycle, pulse rsp<grant_port>_valid for one cycle with rsp_flag = db_rsp_flag; set last_grant = grant_port; go to IDLE.
REQ-026 WAIT timeout: if the timer reaches TIMEOUT-1 with no reply:
  - next cycle, pulse rsp<grant_port>_valid with flag 4'b0000;
  - increment timeout_cnt, saturating at 255;
  - set last_grant = grant_port; go to IDLE.
REQ-027 db_rsp_valid in the same cycle as the timeout SHALL be treated as a normal reply; no timeout is counted.
REQ-028 db_rsp_valid in IDLE or ISSUE SHALL be ignored.
REQ-029 Latency: reqN_valid in cycle T into an empty queue with the FSM in IDLE gives db_valid = 1 in cycle T+2.
REQ-030 Latency: db_rsp_valid in cycle R gives rspN_valid = 1 in cycle R+1.
REQ-031 rspN_flag SHALL hold its value between pulses; rsp0_valid and rsp1_valid are never high in the same cycle.

Reset
REQ-032 eth_rst_n low SHALL asynchronously force:
  - state IDLE, both queues empty, timer 0;
  - db_valid, db_key, db_flag = 0;
  - rsp0/1_valid, rsp0/1_flag = 0;
  - all counters 0;
  - last_grant = 1, so port 0 wins the first tie.
REQ-033 Reset asserted mid-request SHALL discard the outstanding request and all queued entries; after release, a late db_rsp_valid SHALL be ignored.

Verification
REQ-034 Single request: port0 key=96'hA5..01, flag 4'b0011 at T; db_ready tied 1; db_rsp_flag 4'b0100 at R.
  -> db_valid at T+2 with that key/flag; rsp0_valid at R+1 with flag 4'b0100; rsp1_valid stays 0.
REQ-035 Tie and alternation: both ports request at the same cycle, three times each.
  -> DB order is 0,1,0,1,0,1; each reply is routed to the matching port.
REQ-036 Backpressure: db_ready held 0 for 10 cycles during ISSUE.
  -> db_valid/db_key stable throughout; one request is issued.
REQ-037 Overflow: 6 back-to-back port1 requests while the DB never replies, FIFO_DEPTH=4, TIMEOUT=64.
  -> one request issued, 4 queued, drop_cnt1 = 1.
  -> each request gets rsp1_valid with flag 0, 64 cycles after acceptance; timeout_cnt = 5.
REQ-038 Race: db_rsp_valid (flag 4'b0100) arrives in the timer = TIMEOUT-1 cycle.
  -> rsp flag is 4'b0100; timeout_cnt unchanged.
REQ-039 Reset in WAIT, then a db_rsp_valid after release.
  -> no rsp pulse; all outputs 0; the next request is issued normally.
